// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic ops and bit-serial shifts.
// Rev 1.0
`default_nettype none

module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [4:0]      r_op;
  logic [XLEN-1:0] r_result;
  logic [SHW-1:0]  r_cnt;
  logic            r_zero;
  logic            r_illegal;

  logic            w_in_xfer;
  logic            w_is_shift;
  logic [SHW-1:0]  w_amt;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_ill;
  logic [XLEN-1:0] w_shift_res;

  assign inReady    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && outReady);
  assign outValid   = (r_state == ST_DONE);
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal    = r_illegal;
  assign w_in_xfer  = inValid && inReady;
  assign w_amt      = operandB[SHW-1:0];
  assign w_is_shift = (aluControl == OP_SLL) || (aluControl == OP_SRL) ||
                      (aluControl == OP_SRA);

  // Shift ops load the unshifted source; the SHIFT state walks it one bit per cycle.
  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (aluControl)
      OP_ADD:  w_alu_res = operandA + operandB;
      OP_SUB:  w_alu_res = operandA - operandB;
      OP_AND:  w_alu_res = operandA & operandB;
      OP_OR:   w_alu_res = operandA | operandB;
      OP_XOR:  w_alu_res = operandA ^ operandB;
      OP_SLT:  w_alu_res = XLEN'($signed(operandA) < $signed(operandB));
      OP_SLTU: w_alu_res = XLEN'(operandA < operandB);
      OP_SLL, OP_SRL, OP_SRA: w_alu_res = operandA;
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_shift_res = r_result;
    case (r_op)
      OP_SLL:  w_shift_res = {r_result[XLEN-2:0], 1'b0};
      OP_SRL:  w_shift_res = {1'b0, r_result[XLEN-1:1]};
      OP_SRA:  w_shift_res = {r_result[XLEN-1], r_result[XLEN-1:1]};
      default: w_shift_res = r_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_in_xfer) begin
      r_op      <= aluControl;
      r_result  <= w_alu_res;
      r_zero    <= (w_alu_res == '0);
      r_illegal <= w_alu_ill;
      if (w_is_shift && (w_amt != '0)) begin
        r_state <= ST_SHIFT;
        r_cnt   <= w_amt;
      end else begin
        r_state <= ST_DONE;
        r_cnt   <= '0;
      end
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_result <= w_shift_res;
          r_zero   <= (w_shift_res == '0);
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (outReady) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a latency/result model.
// Rev 1.0
`default_nettype none

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  aluControl = '0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady), .aluControl(aluControl),
    .operandA(operandA), .operandB(operandB),
    .outValid(outValid), .outReady(outReady),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operation value plus the number of edges until the result is presented.
  function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic il, output int lat);
    int k;
    k = int'(b[4:0]);
    r = '0; il = 1'b0; lat = 1;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd6: r = (a < b) ? 32'd1 : 32'd0;
      5'd7: begin r = a << k; lat = 1 + k; end
      5'd8: begin r = a >> k; lat = 1 + k; end
      5'd9: begin r = 32'($signed(a) >>> k); lat = 1 + k; end
      default: il = 1'b1;
    endcase
  endfunction

  logic        m_have = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_res = '0;
  logic        m_ill = 1'b0;
  logic        m_fresh = 1'b1;
  logic        exp_ov;
  logic        exp_ir;

  assign exp_ov = m_have && (m_wait == 0);
  assign exp_ir = !m_have || (exp_ov && outReady);

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] r;
    logic        il;
    int          lat;
    if (!rst_n) begin
      m_have  <= 1'b0;
      m_wait  <= 0;
      m_res   <= '0;
      m_ill   <= 1'b0;
      m_fresh <= 1'b1;
    end else if (inValid && exp_ir) begin
      ref_op(aluControl, operandA, operandB, r, il, lat);
      m_have  <= 1'b1;
      m_wait  <= lat - 1;
      m_res   <= r;
      m_ill   <= il;
      m_fresh <= 1'b0;
    end else if (m_have && m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (m_have && outReady) begin
      m_have <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("outValid", 64'(outValid), 64'(exp_ov));
    chk("inReady", 64'(inReady), 64'(exp_ir));
    if (exp_ov || m_fresh) begin
      chk("result", 64'(result), 64'(m_res));
      chk("zero", 64'(zero), m_fresh ? 64'd0 : 64'(m_res == 32'd0));
      chk("illegal", 64'(illegal), 64'(m_ill));
    end
  end

  // Called at posedge+1; presents one request, then waits for the presented result.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy_after, input logic [31:0] er,
                       input logic ez, input logic ei, input int elat);
    int lat;
    inValid = 1'b1; aluControl = op; operandA = a; operandB = b; outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; aluControl = 5'($urandom); operandA = $urandom; operandB = $urandom;
    outReady = rdy_after;
    lat = 1;
    while (!outValid && lat < 200) begin
      if (elat > 1) chk({name, "_busy_inReady"}, 64'(inReady), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(elat));
    chk({name, "_result"}, 64'(result), 64'(er));
    chk({name, "_zero"}, 64'(zero), 64'(ez));
    chk({name, "_illegal"}, 64'(illegal), 64'(ei));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_inReady", 64'(inReady), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;

    do_op("add_wrap", 5'b00000, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1);
    do_op("sub", 5'b00001, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
    do_op("slt", 5'b00101, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0, 1);
    do_op("sltu", 5'b00110, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1);
    do_op("sra31", 5'b01001, 32'h80000000, 32'd31, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32);
    do_op("sll0", 5'b00111, 32'h1234ABCD, 32'hFFFFFF00, 1'b1, 32'h1234ABCD, 1'b0, 1'b0, 1);
    do_op("nop", 5'b11111, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1'b1, 1);
    do_op("undef", 5'b01100, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1'b1, 1);

    do_op("bp_add", 5'b00000, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", 64'(result), 64'd7);
      chk("bp_hold_inReady", 64'(inReady), 64'd0);
    end
    inValid = 1'b1; outReady = 1'b1; aluControl = 5'b00100;
    operandA = 32'hF0; operandB = 32'hFF;
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("bp_xor_valid", 64'(outValid), 64'd1);
    chk("bp_xor_result", 64'(result), 64'h0F);

    @(posedge clk); #1;
    inValid = 1'b1; aluControl = 5'b01000; operandA = 32'hDEADBEEF; operandB = 32'd20;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outValid", 64'(outValid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("post_rst_add", 5'b00000, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0, 1);

    for (int i = 0; i < 1500; i++) begin
      int sel;
      @(posedge clk); #1;
      sel = $urandom_range(0, 11);
      inValid    = ($urandom_range(0, 9) < 7);
      aluControl = (sel == 11) ? 5'b11111 : 5'(sel);
      operandA   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      operandB   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (aluControl >= 5'd7 && aluControl <= 5'd9 && $urandom_range(0, 1) == 0)
        operandB = {operandB[31:5], 5'($urandom_range(0, 2))};
      outReady   = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    inValid = 1'b0; outReady = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_outValid", 64'(outValid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
